// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch front end: widths, control-flow opcodes, fetch states.
package isa_pkg;

  localparam int unsigned AW = 12;
  localparam int unsigned IW = 19;

  // Opcode prefixes, matched against the top bits of the instruction word
  localparam logic [4:0] OP_JMP = 5'b11100;
  localparam logic [4:0] OP_JSB = 5'b11101;
  localparam logic [5:0] OP_RET = 6'b111100;
  localparam logic [2:0] OP_BR  = 3'b101;

  typedef enum logic [1:0] {
    RUN,
    HALT,
    ERR
  } fetch_state_e;

endpackage

// File: rtl/return_stack.sv
// Hardware return-address stack. push and pop are mutually exclusive; both are ignored at the
// corresponding boundary (full / empty), which the caller also detects and treats as an error.
module return_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  // sp counts entries in use; one extra bit distinguishes full from empty
  logic [PtrW:0]   sp_q, sp_d;
  logic [AW-1:0]   stack_q [DEPTH];
  logic [AW-1:0]   stack_d [DEPTH];
  logic [PtrW-1:0] top_idx;

  assign top_idx = sp_q[PtrW-1:0] - PtrW'(1);
  assign dout    = stack_q[top_idx];
  assign full    = (sp_q == (PtrW+1)'(DEPTH));
  assign empty   = (sp_q == '0);

  // Next-state: write at sp on push, retreat sp on pop
  always_comb begin
    stack_d = stack_q;
    sp_d    = sp_q;
    if (push && !full) begin
      stack_d[sp_q[PtrW-1:0]] = din;
      sp_d = sp_q + (PtrW+1)'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - (PtrW+1)'(1);
    end
  end

  // Stack storage and pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      sp_q    <= sp_d;
      stack_q <= stack_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, predecodes JMP/JSB/RET against a local return
// stack, takes branch redirects from execute and hands instructions to decode via valid/ready.
module fetch_sequencer #(
  parameter int unsigned   AW          = isa_pkg::AW,
  parameter int unsigned   IW          = isa_pkg::IW,
  parameter int unsigned   STACK_DEPTH = 8,
  parameter logic [AW-1:0] RESET_PC    = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_instr,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [IW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  input  logic          br_valid,
  input  logic [AW-1:0] br_target,
  input  logic          halt_req,
  output logic          halted,
  output logic          stk_err
);

  import isa_pkg::*;

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          if_valid_q, if_valid_d;
  logic [IW-1:0] if_instr_q, if_instr_d;
  logic [AW-1:0] if_pc_q, if_pc_d;
  logic          stk_err_q, stk_err_d;

  logic          push, pop;
  logic [AW-1:0] pc_inc, stk_dout;
  logic          stk_full, stk_empty;
  logic          is_jmp, is_jsb, is_ret, can_load;

  assign pc_inc   = pc_q + AW'(1);
  assign is_jmp   = (imem_instr[IW-1 -: 5] == OP_JMP);
  assign is_jsb   = (imem_instr[IW-1 -: 5] == OP_JSB);
  assign is_ret   = (imem_instr[IW-1 -: 6] == OP_RET);
  assign can_load = !if_valid_q || if_ready;

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .AW    (AW)
  ) u_return_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Fetch FSM, PC update and output-register load
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q && !if_ready;  // held word drains when decode takes it
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    stk_err_d  = stk_err_q;
    push       = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      RUN: begin
        if (br_valid) begin
          // Redirect wins even over a stalled word: squash it and refetch from the target
          if_valid_d = 1'b0;
          pc_d       = br_target;
        end else if (!halt_req && can_load) begin
          if ((is_jsb && stk_full) || (is_ret && stk_empty)) begin
            state_d   = ERR;
            stk_err_d = 1'b1;
          end else begin
            if_valid_d = 1'b1;
            if_instr_d = imem_instr;
            if_pc_d    = pc_q;
            if (is_jmp) begin
              pc_d = imem_instr[AW-1:0];
            end else if (is_jsb) begin
              push = 1'b1;
              pc_d = imem_instr[AW-1:0];
            end else if (is_ret) begin
              pop  = 1'b1;
              pc_d = stk_dout;
            end else begin
              pc_d = pc_inc;
            end
          end
        end
        if (halt_req && !if_valid_d) state_d = HALT;
      end
      HALT, ERR: ;
      default: state_d = RUN;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      stk_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      stk_err_q  <= stk_err_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign halted    = (state_q == HALT);
  assign stk_err   = stk_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural combinational instruction memory.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [11:0] imem_addr;
  logic [18:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [18:0] if_instr;
  logic [11:0] if_pc;
  logic        br_valid;
  logic [11:0] br_target;
  logic        halt_req;
  logic        halted;
  logic        stk_err;

  logic [18:0] mem [4096];

  int total = 0;
  int bad   = 0;

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .halt_req   (halt_req),
    .halted     (halted),
    .stk_err    (stk_err)
  );

  assign imem_instr = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] enc_jmp(input logic [11:0] t);
    return {5'b11100, 2'b00, t};
  endfunction

  function automatic logic [18:0] enc_jsb(input logic [11:0] t);
    return {5'b11101, 2'b00, t};
  endfunction

  function automatic logic [18:0] enc_ret();
    return {6'b111100, 13'd0};
  endfunction

  // Every word defaults to a non-control op whose value equals its address
  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 19'(i);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    if_ready  = 1'b1;
    br_valid  = 1'b0;
    br_target = '0;
    halt_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [11:0] pc, input logic [18:0] instr);
    check_eq({tag, ".valid"}, 32'(if_valid), 32'd1);
    check_eq({tag, ".pc"}, 32'(if_pc), 32'(pc));
    check_eq({tag, ".instr"}, 32'(if_instr), 32'(instr));
  endtask

  initial begin
    clear_mem();
    do_reset();

    // Reset state, then straight-line fetch and backpressure
    check_eq("rst.valid", 32'(if_valid), 32'd0);
    check_eq("rst.instr", 32'(if_instr), 32'd0);
    check_eq("rst.pc", 32'(if_pc), 32'd0);
    check_eq("rst.addr", 32'(imem_addr), 32'd0);
    check_eq("rst.halted", 32'(halted), 32'd0);
    check_eq("rst.err", 32'(stk_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("line", 12'(i), 19'(i));
    end
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("stall", 12'd2, 19'd2);
      check_eq("stall.addr", 32'(imem_addr), 32'd3);
    end
    if_ready = 1'b1;
    step();
    expect_out("unstall", 12'd3, 19'd3);

    // Call/return and jumps: 0 -> 14 -> 20 -> 15 -> 10 -> 3 -> 4
    clear_mem();
    mem[0]  = enc_jmp(12'd14);
    mem[14] = enc_jsb(12'd20);
    mem[20] = enc_ret();
    mem[15] = enc_jmp(12'd10);
    mem[10] = enc_jmp(12'd3);
    do_reset();
    step(); expect_out("call0", 12'd0, enc_jmp(12'd14));
    step(); expect_out("call14", 12'd14, enc_jsb(12'd20));
    step(); expect_out("call20", 12'd20, enc_ret());
    step(); expect_out("ret15", 12'd15, enc_jmp(12'd10));
    step(); expect_out("jmp10", 12'd10, enc_jmp(12'd3));
    step(); expect_out("jmp3", 12'd3, 19'd3);
    step(); expect_out("jmp4", 12'd4, 19'd4);

    // Overflow: nine nested calls with an eight-entry stack
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = enc_jsb(12'(i + 1));
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      expect_out("nest", 12'(i), enc_jsb(12'(i + 1)));
      check_eq("nest.err", 32'(stk_err), 32'd0);
    end
    step();
    check_eq("ovf.err", 32'(stk_err), 32'd1);
    check_eq("ovf.valid", 32'(if_valid), 32'd0);
    repeat (3) step();
    check_eq("ovf.still_idle", 32'(if_valid), 32'd0);
    check_eq("ovf.addr", 32'(imem_addr), 32'd8);
    check_eq("ovf.halted", 32'(halted), 32'd0);

    // RET on an empty stack (also shows reset discarded the earlier pushes)
    clear_mem();
    mem[0] = enc_ret();
    do_reset();
    check_eq("unf.rst_err", 32'(stk_err), 32'd0);
    step();
    check_eq("unf.err", 32'(stk_err), 32'd1);
    check_eq("unf.valid", 32'(if_valid), 32'd0);

    // Branch squash while stalled
    clear_mem();
    do_reset();
    step(); step();
    expect_out("br.pre", 12'd1, 19'd1);
    if_ready = 1'b0;
    step();
    expect_out("br.held", 12'd1, 19'd1);
    br_valid  = 1'b1;
    br_target = 12'd11;
    step();
    br_valid = 1'b0;
    check_eq("br.squash", 32'(if_valid), 32'd0);
    check_eq("br.addr", 32'(imem_addr), 32'd11);
    step();
    expect_out("br.target", 12'd11, 19'd11);

    // PC wrap at the top of memory
    clear_mem();
    mem[0] = enc_jmp(12'hFFF);
    do_reset();
    step(); expect_out("wrap.j", 12'd0, enc_jmp(12'hFFF));
    step(); expect_out("wrap.top", 12'hFFF, 19'hFFF);
    check_eq("wrap.addr", 32'(imem_addr), 32'd0);
    step(); expect_out("wrap.zero", 12'd0, enc_jmp(12'hFFF));

    // Halt after pc 5 drains; dropping halt_req does not resume
    clear_mem();
    do_reset();
    repeat (6) step();
    expect_out("halt.pre", 12'd5, 19'd5);
    halt_req = 1'b1;
    step();
    check_eq("halt.halted", 32'(halted), 32'd1);
    check_eq("halt.valid", 32'(if_valid), 32'd0);
    halt_req = 1'b0;
    repeat (3) step();
    check_eq("halt.stays", 32'(halted), 32'd1);
    check_eq("halt.no6", 32'(if_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
